evo_csr_arb: RTL and testbench

- Round-robin arbiter that shares one Avalon-MM CSR slave port among NUM_MSTR CSR masters. Typical masters are the I2C control path and on-chip debug logic; typical slaves are the XB info and PMUX CSR blocks.
- Per-master lock holds the grant across multi-access sequences, e.g. an indirect "write index, then read value" pair, so another master cannot interleave.
- Tracks one outstanding read and routes readdatavalid back to its issuer.
- A read timeout guarantees forward progress if the slave never returns data.

---
 rtl/evo_csr_arb.sv | 121 ++++++++++++
 tb/tb_evo_csr_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evo_csr_arb.sv
// evo_csr_arb: round-robin arbiter sharing one Avalon-MM CSR slave among NUM_MSTR masters,
// with per-master grant lock, a single tracked outstanding read and a read timeout.
module evo_csr_arb #(
    parameter int NUM_MSTR = 2,
    parameter int CSR_AWIDTH = 16,
    parameter int CSR_DWIDTH = 32,
    parameter int RD_TIMEOUT = 64,
    parameter logic [CSR_DWIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MSTR*CSR_AWIDTH-1:0] m_address,
    input  logic [NUM_MSTR-1:0]            m_read,
    input  logic [NUM_MSTR-1:0]            m_write,
    input  logic [NUM_MSTR*CSR_DWIDTH-1:0] m_writedata,
    input  logic [NUM_MSTR-1:0]            m_lock,
    output logic [NUM_MSTR-1:0]            m_waitrequest,
    output logic [NUM_MSTR-1:0]            m_readdatavalid,
    output logic [CSR_DWIDTH-1:0]          m_readdata,
    output logic [CSR_AWIDTH-1:0]          s_address,
    output logic                           s_read,
    output logic                           s_write,
    output logic [CSR_DWIDTH-1:0]          s_writedata,
    input  logic                           s_waitrequest,
    input  logic                           s_readdatavalid,
    input  logic [CSR_DWIDTH-1:0]          s_readdata,
    output logic                           rd_timeout
);
    localparam int PW = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1;
    localparam int CW = $clog2(RD_TIMEOUT);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    // Operands are both below NUM_MSTR, so one conditional subtract is a full modulo.
    function automatic logic [PW-1:0] f_wrap(input logic [PW:0] v);
        return (v >= (PW+1)'(NUM_MSTR)) ? PW'(v - (PW+1)'(NUM_MSTR)) : PW'(v);
    endfunction

    logic [1:0]            r_state;
    logic [PW-1:0]         r_grant;
    logic [PW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;
    logic [NUM_MSTR-1:0]   w_req;
    logic [2*NUM_MSTR-1:0] w_rot;
    logic [PW-1:0]         w_pick;
    logic [PW-1:0]         w_ptr_nxt;
    logic                  w_own;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ret;

    assign w_req = m_read | m_write;
    assign w_rot = {w_req, w_req} >> r_ptr;
    assign w_ptr_nxt = f_wrap({1'b0, r_grant} + 1'b1);
    assign w_own = r_state == ST_OWN;

    // Scanning downwards lets the requester closest to r_ptr win.
    always_comb begin
        w_pick = r_ptr;
        for (int i = NUM_MSTR - 1; i >= 0; i--)
            if (w_rot[i]) w_pick = f_wrap({1'b0, r_ptr} + (PW+1)'(i));
    end

    assign s_address = m_address[r_grant*CSR_AWIDTH +: CSR_AWIDTH];
    assign s_writedata = m_writedata[r_grant*CSR_DWIDTH +: CSR_DWIDTH];
    assign s_read = w_own & m_read[r_grant];
    assign s_write = w_own & m_write[r_grant];
    assign w_rd_acc = s_read & ~s_waitrequest;
    assign w_wr_acc = s_write & ~s_waitrequest;
    assign w_ret = s_readdatavalid | (r_cnt == CW'(RD_TIMEOUT - 1));

    always_comb begin
        m_waitrequest = '1;
        if (w_own) m_waitrequest[r_grant] = s_waitrequest;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
            m_readdatavalid <= '0;
            m_readdata <= '0;
            rd_timeout <= 1'b0;
        end else begin
            m_readdatavalid <= '0;
            rd_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_pick;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_rd_acc) begin
                        r_state <= ST_RDWAIT;
                        r_cnt <= '0;
                    end else if ((w_wr_acc || !w_req[r_grant]) && !m_lock[r_grant]) begin
                        r_state <= ST_IDLE;
                        r_ptr <= w_ptr_nxt;
                    end
                end
                ST_RDWAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Real data takes priority over a coincident timeout.
                    if (w_ret) begin
                        m_readdatavalid[r_grant] <= 1'b1;
                        m_readdata <= s_readdatavalid ? s_readdata : TIMEOUT_DATA;
                        rd_timeout <= ~s_readdatavalid;
                        r_state <= m_lock[r_grant] ? ST_OWN : ST_IDLE;
                        if (!m_lock[r_grant]) r_ptr <= w_ptr_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evo_csr_arb.sv
// tb_evo_csr_arb: directed scenarios plus randomized rounds against a memory-backed slave model.
module tb_evo_csr_arb;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [2*AW-1:0] m_address = '0;
    logic [1:0]    m_read = '0;
    logic [1:0]    m_write = '0;
    logic [1:0]    m_lock = '0;
    logic [2*DW-1:0] m_writedata = '0;
    logic [1:0]    m_waitrequest;
    logic [1:0]    m_readdatavalid;
    logic [DW-1:0] m_readdata;
    logic [AW-1:0] s_address;
    logic          s_read;
    logic          s_write;
    logic [DW-1:0] s_writedata;
    logic          s_waitrequest = 1'b0;
    logic          s_readdatavalid = 1'b0;
    logic [DW-1:0] s_readdata = '0;
    logic          rd_timeout;

    int n_tests = 0;
    int n_fail = 0;
    int ptr = 0;
    logic [15:0] ad [2];
    logic [31:0] wd [2];
    bit act [2];
    bit wrq [2];
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    evo_csr_arb dut (
        .clk(clk), .rstn(rstn),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_lock(m_lock),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
        .rd_timeout(rd_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Masters in act[] request together; the slave is a memory with random wait states and latency.
    task automatic run_round(output int first_m);
        int q[$];
        int wcnt, lat, pend_m, ret_m, cyc, g;
        bit ret_due;
        logic [31:0] rd_val, ret_val;
        logic [1:0] exp_wr;
        for (int k = 0; k < 2; k++) if (act[(ptr + k) % 2]) q.push_back((ptr + k) % 2);
        first_m = -1;
        wcnt = $urandom_range(0, 2);
        lat = 0; pend_m = -1; ret_m = 0; ret_due = 0; cyc = 0; rd_val = '0; ret_val = '0;
        while ((act[0] || act[1] || pend_m >= 0 || ret_due) && cyc < 200) begin
            for (int i = 0; i < 2; i++) begin
                m_read[i] = act[i] && !wrq[i];
                m_write[i] = act[i] && wrq[i];
                m_address[i*AW +: AW] = ad[i];
                m_writedata[i*DW +: DW] = wd[i];
            end
            s_waitrequest = wcnt > 0;
            s_readdatavalid = pend_m >= 0 && lat == 0;
            s_readdata = s_readdatavalid ? rd_val : $urandom;
            #1;
            chk("rr_rdv", m_readdatavalid, ret_due ? 2'(1 << ret_m) : 2'b00);
            chk("rr_no_timeout", rd_timeout, 0);
            if (ret_due) chk("rr_rdata", m_readdata, ret_val);
            ret_due = 0;
            if (s_readdatavalid) begin
                ret_due = 1; ret_m = pend_m; ret_val = rd_val; pend_m = -1;
            end else if (pend_m >= 0) lat--;
            exp_wr = 2'b11;
            if (s_read || s_write) begin
                if (first_m < 0) first_m = int'(s_address[15:8]);
                if (q.size() == 0) chk("rr_spurious_cmd", {s_read, s_write}, 0);
                else begin
                    g = q[0];
                    exp_wr[g] = s_waitrequest;
                    chk("rr_addr", s_address, ad[g]);
                    chk("rr_dir", {s_read, s_write}, wrq[g] ? 2'b01 : 2'b10);
                    if (!s_waitrequest) begin
                        if (wrq[g]) begin
                            chk("rr_wdata", s_writedata, wd[g]);
                            mem[ad[g][7:0]] = wd[g];
                        end else begin
                            pend_m = g; lat = $urandom_range(0, 3); rd_val = mem[ad[g][7:0]];
                        end
                        act[g] = 0;
                        void'(q.pop_front());
                        ptr = (g + 1) % 2;
                        wcnt = $urandom_range(0, 2);
                    end else wcnt--;
                end
            end
            chk("rr_mwait", m_waitrequest, exp_wr);
            tick();
            cyc++;
        end
        chk("rr_bounded", cyc < 200, 1);
        m_read = '0; m_write = '0; s_readdatavalid = 0; s_waitrequest = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        tick(); tick();
        chk("rst_mwait", m_waitrequest, 2'b11);
        chk("rst_rdv", m_readdatavalid, 2'b00);
        chk("rst_rdata", m_readdata, 0);
        chk("rst_sstrobes", {s_read, s_write, rd_timeout}, 3'b000);
        tick(); rstn = 1'b1;

        // Simultaneous reads from reset: master 0 first, gets 0xA, then master 1 gets 0xB.
        mem[8'h20] = 32'hA; mem[8'hB0] = 32'hB;
        act[0] = 1; act[1] = 1; wrq[0] = 0; wrq[1] = 0;
        ad[0] = 16'h0020; ad[1] = 16'h01B0; wd[0] = '0; wd[1] = '0;
        tick(); run_round(first);
        chk("t2_first", first, 0);

        // Single write with zero wait states: command one cycle after the request.
        tick(); m_write[0] = 1; m_address[15:0] = 16'h0010; m_writedata[31:0] = 32'h1; s_waitrequest = 0;
        #1 chk("t1_arb", {s_write, m_waitrequest}, 3'b011);
        tick(); #1;
        chk("t1_sw", s_write, 1);
        chk("t1_addr", s_address, 16'h0010);
        chk("t1_wdata", s_writedata, 32'h1);
        chk("t1_mwait", m_waitrequest, 2'b10);
        tick(); m_write[0] = 0;
        #1 chk("t1_idle", {s_write, m_waitrequest}, 3'b011);
        ptr = 1;

        // Rotation: master 0 was served last, so master 1 wins a tie.
        act[0] = 1; act[1] = 1; wrq[0] = 0; wrq[1] = 0;
        ad[0] = 16'h0020; ad[1] = 16'h01B0;
        tick(); run_round(first);
        chk("rot_first", first, 1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 1'($urandom); wrq[i] = 1'($urandom);
                ad[i] = {8'(i), 1'(i), 7'($urandom)}; wd[i] = $urandom;
            end
            if (!act[0] && !act[1]) act[$urandom_range(0, 1)] = 1;
            tick(); run_round(first);
        end

        // Locked write-then-read by master 1 while master 0 waits.
        tick();
        m_lock[1] = 1; m_write[1] = 1; m_address[31:16] = 16'h0100; m_writedata[63:32] = 32'h2;
        #1 chk("t3_idle", s_write, 0);
        tick(); m_read[0] = 1; m_address[15:0] = 16'h0040;
        #1;
        chk("t3_wr_addr", s_address, 16'h0100);
        chk("t3_wr", {s_read, s_write}, 2'b01);
        chk("t3_wr_data", s_writedata, 32'h2);
        chk("t3_wr_wait", m_waitrequest, 2'b01);
        tick(); m_write[1] = 0; m_read[1] = 1; m_address[31:16] = 16'h0104;
        #1;
        chk("t3_rd_addr", s_address, 16'h0104);
        chk("t3_rd", {s_read, s_write}, 2'b10);
        chk("t3_rd_wait", m_waitrequest, 2'b01);
        tick(); m_read[1] = 0; s_readdatavalid = 1; s_readdata = 32'h1234;
        #1 chk("t3_rdwait", {s_read, m_waitrequest}, 3'b011);
        tick(); s_readdatavalid = 0;
        #1;
        chk("t3_rdv", m_readdatavalid, 2'b10);
        chk("t3_rdata", m_readdata, 32'h1234);
        chk("t3_held_wait", m_waitrequest, 2'b01);
        repeat (3) begin
            tick();
            #1 chk("t3_m0_blocked", s_read, 0);
        end
        tick(); m_lock[1] = 0;
        #1 chk("t3_unlock", s_read, 0);
        tick();
        #1 chk("t3_rearb", s_read, 0);
        tick(); #1;
        chk("t3_m0_rd", s_read, 1);
        chk("t3_m0_addr", s_address, 16'h0040);
        chk("t3_m0_wait", m_waitrequest, 2'b10);
        tick(); m_read[0] = 0; s_readdatavalid = 1; s_readdata = 32'h55;
        tick(); s_readdatavalid = 0;
        #1;
        chk("t3_m0_rdv", m_readdatavalid, 2'b01);
        chk("t3_m0_rdata", m_readdata, 32'h55);

        // Write stalled by five slave wait states, then accepted once.
        tick(); m_write[0] = 1; m_address[15:0] = 16'h0050; m_writedata[31:0] = 32'h77; s_waitrequest = 1;
        #1 chk("t4_idle", s_write, 0);
        repeat (5) begin
            tick(); #1;
            chk("t4_stall_sw", s_write, 1);
            chk("t4_stall_wait", m_waitrequest, 2'b11);
        end
        tick(); s_waitrequest = 0;
        #1;
        chk("t4_sw", s_write, 1);
        chk("t4_accept", m_waitrequest, 2'b10);
        tick(); m_write[0] = 0;
        #1 chk("t4_done", {s_write, m_waitrequest}, 3'b011);

        // Read that the slave never answers.
        tick(); m_read[0] = 1; m_address[15:0] = 16'h0060;
        tick();
        #1 chk("t5_sread", s_read, 1);
        for (k = 1; k <= 80; k++) begin
            tick();
            m_read[0] = 0;
            #1;
            if (m_readdatavalid != 2'b00 || rd_timeout) break;
        end
        // 64 RDWAIT cycles after the accepting cycle, then the registered return.
        chk("t5_latency", k, TO + 1);
        chk("t5_rdv", m_readdatavalid, 2'b01);
        chk("t5_rdata", m_readdata, 32'hDEADBEEF);
        chk("t5_pulse", rd_timeout, 1);
        tick(); s_readdatavalid = 1; s_readdata = 32'h999;
        #1 chk("t5_pulse_end", {rd_timeout, m_readdatavalid}, 3'b000);
        tick(); s_readdatavalid = 0;
        #1;
        chk("t5_late_dropped", m_readdatavalid, 2'b00);
        chk("t5_rdata_kept", m_readdata, 32'hDEADBEEF);

        // Reset in the middle of an outstanding read.
        tick(); m_read[1] = 1; m_address[31:16] = 16'h0190;
        tick();
        #1 chk("t6_sread", s_read, 1);
        tick(); m_read[1] = 0;
        tick(); tick();
        rstn = 0; s_readdatavalid = 1; s_readdata = 32'h1111;
        #1;
        chk("t6_rst_mwait", m_waitrequest, 2'b11);
        chk("t6_rst_rdv", m_readdatavalid, 2'b00);
        chk("t6_rst_rdata", m_readdata, 0);
        chk("t6_rst_strobes", {s_read, s_write, rd_timeout}, 3'b000);
        tick(); tick(); rstn = 1;
        #1 chk("t6_no_rdv_a", m_readdatavalid, 2'b00);
        tick(); s_readdatavalid = 0;
        #1 chk("t6_no_rdv_b", m_readdatavalid, 2'b00);
        ptr = 0;
        act[0] = 1; act[1] = 1; wrq[0] = 0; wrq[1] = 0;
        ad[0] = 16'h0005; ad[1] = 16'h0185;
        tick(); run_round(first);
        chk("t6_first", first, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
